adc_avg_ctrl: RTL
=================

# adc_avg_ctrl

Parametrised successor to the fixed 8-sample ADC averaging front-end. On each synchronisation pulse it requests exactly 2^LOG2_AVG conversions from the ADC and accumulates them. It then outputs their rounded mean with a one-cycle ready strobe. Compared with the previous generation it adds configurable width and depth, signed/unsigned arithmetic, optional rounding, a sample-gap watchdog and overrun/timeout status. It sits between the ADC interface and downstream processing, all on one clock domain.

## Interface
- DATA_W, 12: ADC sample and result width (≥2).
- LOG2_AVG, 3: log2 of the samples per result (0..8); N = 2^LOG2_AVG.
- SIGNED_MODE, 1: 1 = two's-complement samples and arithmetic shift; 0 = unsigned.
- ROUND_EN, 1: 1 = add 2^(LOG2_AVG-1) before the shift; ignored when LOG2_AVG = 0.
- TIMEOUT, 255: maximum idle cycles between accepted samples in ACQ (≥1).
- clk_i  in  1  single clock; all logic is rising-edge.
- reset_i  in  1  synchronous, active-high reset.
- syncro_i  in  1  acquisition trigger, asynchronous; a rising edge starts one acquisition.
- adc_data_req_o  out  1  high while samples are wanted.
- adc_data_rdy_i  in  1  sample-valid qualifier for adc_data_i.
- adc_data_i  in  DATA_W  ADC sample.
- data_o  out  DATA_W  last averaged result, held between results.
- data_rdy_o  out  1  one-cycle pulse when data_o updates.
- busy_o  out  1  high in ACQ and DONE.
- overrun_o  out  1  one-cycle pulse when a trigger edge arrives while busy.
- timeout_o  out  1  sticky watchdog-abort flag.

## Operation
- syncro_i passes through a 2-flop synchroniser, then a rising-edge detector register. The start condition is sync2 = 1 while sync3 = 0.
- FSM states: IDLE, ACQ, DONE.
- IDLE → ACQ on start. On this transition, clear the accumulator, sample counter, watchdog and timeout_o.
- ACQ:
  - adc_data_req_o = 1.
  - Each cycle with adc_data_rdy_i = 1 accepts adc_data_i, sign-extended when SIGNED_MODE = 1 and zero-extended otherwise.
  - The accepted sample is added to the accumulator, and the counter increments.
  - The edge that accepts sample N moves the FSM to DONE.
- ACQ watchdog:
  - The watchdog increments on each cycle without an accepted sample and clears on each accepted sample.
  - When it reaches TIMEOUT, the FSM goes to IDLE, sets timeout_o and emits no data_rdy_o. data_o keeps its previous value.
- DONE:
  - data_o ← (acc + R) >> LOG2_AVG, where R = 2^(LOG2_AVG-1) if ROUND_EN and LOG2_AVG > 0, else 0.
  - The shift is arithmetic when SIGNED_MODE = 1 and logical otherwise. The low DATA_W bits are kept.
  - data_rdy_o = 1 for that one cycle. The FSM then returns to IDLE.
- Accumulator and rounding adder width is DATA_W+LOG2_AVG. The worst case, (2^DATA_W−1)·N + N/2, fits without overflow, so no saturation logic is required.
- adc_data_rdy_i outside ACQ is ignored.
- A start in ACQ or DONE is dropped, overrun_o pulses for 1 cycle and the acquisition in progress is unaffected. A start in the cycle the FSM is in IDLE is always accepted.
- Reset values:
  - FSM = IDLE; all outputs 0: adc_data_req_o, data_o, data_rdy_o, busy_o, overrun_o, timeout_o.
  - Synchroniser, accumulator, counter and watchdog are cleared.
- Reset mid-acquisition aborts it immediately and produces no result.

## Timing
- syncro_i high before edge E0 → start visible after E2. ACQ is entered at E3, so adc_data_req_o and busy_o are high from E3.
- A sample is accepted at the edge where adc_data_rdy_i = 1 in ACQ. This includes the first ACQ cycle.
- Edge EN (the Nth sample) drops adc_data_req_o. At EN+1, data_o updates and data_rdy_o is high for the cycle after EN+1. At EN+2, data_rdy_o and busy_o are low.
- Latency from the last sample to data_rdy_o is 1 cycle. The minimum trigger-to-result time is 3 + N + 1 cycles.
- Timeout abort: TIMEOUT consecutive sample-less ACQ cycles → the next edge drops adc_data_req_o and busy_o, and timeout_o goes high and stays high until the next accepted start or reset.
- overrun_o is asserted for the cycle after the edge that detected the start while busy.

## Test plan
- Unsigned, defaults: trigger, then 8 back-to-back samples 100..107 → sum 828, +4 → data_o = 104. data_rdy_o pulses once, 1 cycle after the 8th sample, and adc_data_req_o falls at the 8th sample edge.
- SIGNED_MODE = 1: 8 samples of 0xFFD (−3) → (−24 + 4) >>> 3 = −3, so data_o = 0xFFD. With ROUND_EN = 0, data_o is also 0xFFD.
- Full scale, unsigned: 8 × 0xFFF with 2-cycle gaps between samples → data_o = 0xFFF, no wrap, and latency is still 1 cycle.
- TIMEOUT = 16: 3 samples, then adc_data_rdy_i held low → abort after 16 idle cycles, timeout_o = 1, no data_rdy_o, data_o unchanged. The next trigger clears timeout_o and completes normally.
- Second syncro_i edge during ACQ → overrun_o pulses for 1 cycle, the first result is correct and no second acquisition starts. A trigger one cycle after DONE→IDLE is accepted.
- reset_i asserted after 4 samples → all outputs are 0 on the next cycle. A new 8-sample acquisition of 0x010 then gives data_o = 0x010 with no residue from before the reset.
- LOG2_AVG = 0 → a single sample is passed through unchanged with the same handshake timing.

Source files
------------

// File: rtl/adc_avg_ctrl.sv
// ADC averaging front-end: on each trigger edge it collects 2^LOG2_AVG samples,
// then emits their (optionally rounded) mean with a one-cycle ready strobe.
module adc_avg_ctrl #(
  parameter int DATA_W      = 12,
  parameter int LOG2_AVG    = 3,
  parameter int SIGNED_MODE = 1,
  parameter int ROUND_EN    = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              syncro_i,
  output logic              adc_data_req_o,
  input  logic              adc_data_rdy_i,
  input  logic [DATA_W-1:0] adc_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_rdy_o,
  output logic              busy_o,
  output logic              overrun_o,
  output logic              timeout_o
);

  localparam int ACC_W  = DATA_W + LOG2_AVG;
  localparam int CNT_W  = LOG2_AVG + 1;
  localparam int WD_W   = $clog2(TIMEOUT + 1);
  localparam int RND_SH = (LOG2_AVG > 0) ? LOG2_AVG - 1 : 0;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_AVG) - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [ACC_W-1:0] RND_ADD  =
    (ROUND_EN != 0 && LOG2_AVG > 0) ? (ACC_W'(1) << RND_SH) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_sync1;
  logic              r_sync2;
  logic              r_sync3;
  logic              r_start;
  logic [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic [WD_W-1:0]   r_wd;
  logic              r_req;
  logic              r_rdy;
  logic              r_busy;
  logic              r_ovr;
  logic              r_tmo;
  logic [DATA_W-1:0] r_data;

  logic [ACC_W-1:0]  w_sample_ext;
  logic [ACC_W-1:0]  w_sum;
  logic [DATA_W-1:0] w_avg;

  // Widen the sample to accumulator width according to the arithmetic mode.
  generate
    if (LOG2_AVG == 0) begin : g_ext_none
      assign w_sample_ext = adc_data_i;
    end else if (SIGNED_MODE != 0) begin : g_ext_sign
      assign w_sample_ext = {{LOG2_AVG{adc_data_i[DATA_W-1]}}, adc_data_i};
    end else begin : g_ext_zero
      assign w_sample_ext = {{LOG2_AVG{1'b0}}, adc_data_i};
    end
  endgenerate

  assign w_sum = r_acc + RND_ADD;

  generate
    if (SIGNED_MODE != 0) begin : g_shift_arith
      logic signed [ACC_W-1:0] w_sum_s;
      assign w_sum_s = $signed(w_sum);
      assign w_avg   = DATA_W'(w_sum_s >>> LOG2_AVG);
    end else begin : g_shift_logic
      assign w_avg = DATA_W'(w_sum >> LOG2_AVG);
    end
  endgenerate

  // Two-flop synchroniser followed by a registered rising-edge detector.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_sync1 <= syncro_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_start <= r_sync2 & ~r_sync3;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_wd    <= '0;
      r_req   <= 1'b0;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
      r_ovr   <= 1'b0;
      r_tmo   <= 1'b0;
      r_data  <= '0;
    end else begin
      r_rdy <= 1'b0;
      r_ovr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_start) begin
            r_state <= S_ACQ;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_wd    <= '0;
            r_tmo   <= 1'b0;
            r_req   <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_ACQ: begin
          if (r_start) begin
            r_ovr <= 1'b1;
          end
          if (adc_data_rdy_i) begin
            r_acc <= r_acc + w_sample_ext;
            r_cnt <= r_cnt + 1'b1;
            r_wd  <= '0;
            if (r_cnt == LAST_CNT) begin
              r_state <= S_DONE;
              r_req   <= 1'b0;
            end
          end else if (r_wd == WD_LAST) begin
            // Sample source went quiet: abandon without touching data_o.
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_tmo   <= 1'b1;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        S_DONE: begin
          if (r_start) begin
            r_ovr <= 1'b1;
          end
          // busy stays high through the strobe cycle and drops from IDLE.
          r_data  <= w_avg;
          r_rdy   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign adc_data_req_o = r_req;
  assign data_o         = r_data;
  assign data_rdy_o     = r_rdy;
  assign busy_o         = r_busy;
  assign overrun_o      = r_ovr;
  assign timeout_o      = r_tmo;

endmodule
